// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter with pending-register scoreboard.
// Optional macro WB_FWD_EN enables same-cycle forwarding from the write stage.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_rd,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_rd,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    output logic        iss_waw,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hazard,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        rf_we,
    output logic        fwd_rs1_valid,
    output logic        fwd_rs2_valid,
    output logic [31:0] fwd_data
);
    logic        ptr;
    logic [31:0] pending;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    // Grant: the requester not granted last wins contention; ptr=1 favours B.
    always_comb begin
        a_ready = !rst && a_valid && (!b_valid || !ptr);
        b_ready = !rst && b_valid && (!a_valid || ptr);
    end
    // Pointer flips to the other requester after every grant.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (a_ready)
            ptr <= 1'b1;
        else if (b_ready)
            ptr <= 1'b0;
    end
    // Output stage: one registered write per cycle; x0 writes are swallowed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_rd    <= 5'd0;
            rf_wdata <= 32'd0;
        end else if (a_ready) begin
            rf_we    <= |a_rd;
            rf_rd    <= a_rd;
            rf_wdata <= a_data;
        end else if (b_ready) begin
            rf_we    <= |b_rd;
            rf_rd    <= b_rd;
            rf_wdata <= b_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end
    // Scoreboard set/clear masks; x0 is never tracked.
    always_comb begin
        set_mask = (iss_valid && |iss_rd) ? (32'd1 << iss_rd) : 32'd0;
        clr_mask = rf_we ? (32'd1 << rf_rd) : 32'd0;
    end
    // Clear is applied before set so a new producer keeps the bit pending.
    always_ff @(posedge clk) begin
        if (rst)
            pending <= 32'd0;
        else
            pending <= (pending & ~clr_mask) | set_mask;
    end
    // Forwarding from the write stage, hazard and WAW detection.
    always_comb begin
`ifdef WB_FWD_EN
        fwd_rs1_valid = rf_we && |rs1 && rs1 == rf_rd;
        fwd_rs2_valid = rf_we && |rs2 && rs2 == rf_rd;
        fwd_data      = rf_wdata;
`else
        fwd_rs1_valid = 1'b0;
        fwd_rs2_valid = 1'b0;
        fwd_data      = 32'd0;
`endif
        hazard  = (|rs1 && pending[rs1] && !fwd_rs1_valid) ||
                  (|rs2 && pending[rs2] && !fwd_rs2_valid);
        iss_waw = !rst && iss_valid && |iss_rd && pending[iss_rd];
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed and randomized checks of wb_arbiter against a behavioural model.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, iss_valid = 1'b0;
    logic [4:0]  a_rd = '0, b_rd = '0, iss_rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, iss_waw, hazard, rf_we, fwd_rs1_valid, fwd_rs2_valid;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata, fwd_data;
    int vectors = 0;
    int miscompares = 0;
`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // Behavioural model: set of pending registers, last granted requester, write stage.
    bit          m_pend [32];
    bit          m_last_b = 1'b1;
    bit          m_we = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;

    wb_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_waw(iss_waw),
        .rs1(rs1), .rs2(rs2), .hazard(hazard),
        .rf_rd(rf_rd), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .fwd_rs1_valid(fwd_rs1_valid), .fwd_rs2_valid(fwd_rs2_valid), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    function automatic bit e_a_ready();
        return !rst && a_valid && (!b_valid || m_last_b);
    endfunction
    function automatic bit e_b_ready();
        return !rst && b_valid && (!a_valid || !m_last_b);
    endfunction
    function automatic bit e_fwd(input logic [4:0] rs);
        return FWD && m_we && rs != 0 && rs == m_rd;
    endfunction
    function automatic bit e_hazard();
        return (rs1 != 0 && m_pend[rs1] && !e_fwd(rs1)) || (rs2 != 0 && m_pend[rs2] && !e_fwd(rs2));
    endfunction
    function automatic bit e_waw();
        return !rst && iss_valid && iss_rd != 0 && m_pend[iss_rd];
    endfunction

    task automatic model_update();
        bit ga, gb;
        ga = e_a_ready();
        gb = e_b_ready();
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_last_b = 1'b1;
            m_we = 1'b0; m_rd = '0; m_data = '0;
        end else begin
            if (m_we) m_pend[m_rd] = 1'b0;
            if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
            if (ga) begin m_we = a_rd != 0; m_rd = a_rd; m_data = a_data; m_last_b = 1'b0; end
            else if (gb) begin m_we = b_rd != 0; m_rd = b_rd; m_data = b_data; m_last_b = 1'b1; end
            else m_we = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; iss_valid = 0;
        a_rd = 0; b_rd = 0; iss_rd = 0; rs1 = 0; rs2 = 0; a_data = 0; b_data = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; a_valid = 1; b_valid = 1; iss_valid = 1; iss_rd = 3;
        #1;
        vectors++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: a_ready=%b b_ready=%b, required 0 0", a_ready, b_ready);
        end
        tick();
        tick();
        idle();
        rst = 0;
        #1;
        vectors++;
        if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_out: we=%b rd=%0d wdata=%h, required 0 0 0", rf_we, rf_rd, rf_wdata);
        end
        vectors++;
        if (fwd_rs1_valid !== 1'b0 || fwd_rs2_valid !== 1'b0 || fwd_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_fwd: %b %b %h, required 0 0 0", fwd_rs1_valid, fwd_rs2_valid, fwd_data);
        end
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); rs2 = 5'(31 - r);
            #1;
            vectors++;
            if (hazard !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_pending: rs1=%0d hazard=%b, required 0", r, hazard);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_single();
        do_reset();
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        #1;
        vectors++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL single_grant: a_ready=%b b_ready=%b, required 1 0", a_ready, b_ready);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_write: we=%b rd=%0d wdata=%h, required 1 5 deadbeef", rf_we, rf_rd, rf_wdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_valid = 1; a_rd = 5'(10 + i); a_data = 32'hA000_0000 + i;
            b_valid = 1; b_rd = 5'(20 + i); b_data = 32'hB000_0000 + i;
            #1;
            vectors++;
            if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: a_ready=%b b_ready=%b, required %b %b", i, a_ready, b_ready, i % 2 == 0, i % 2 == 1);
            end
            if (i > 0) begin
                vectors++;
                if (rf_we !== 1'b1 || rf_rd !== m_rd || rf_wdata !== m_data) begin
                    miscompares++;
                    $display("FAIL rr_write[%0d]: we=%b rd=%0d wdata=%h, required 1 %0d %h", i, rf_we, rf_rd, rf_wdata, m_rd, m_data);
                end
            end
            tick();
        end
        idle();
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_rd !== 5'd23 || rf_wdata !== 32'hB000_0003) begin
            miscompares++;
            $display("FAIL rr_last: we=%b rd=%0d wdata=%h, required 1 23 b0000003", rf_we, rf_rd, rf_wdata);
        end
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        iss_valid = 1; iss_rd = 7;
        tick();
        idle(); rs1 = 7;
        #1;
        vectors++;
        if (hazard !== 1'b1) begin
            miscompares++;
            $display("FAIL hz_pending: hazard=%b, required 1", hazard);
        end
        b_valid = 1; b_rd = 7; b_data = 32'h1234_5678;
        #1;
        vectors++;
        if (b_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL hz_b_grant: b_ready=%b, required 1", b_ready);
        end
        tick();
        idle(); rs1 = 7;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || hazard !== !FWD || fwd_rs1_valid !== FWD) begin
            miscompares++;
            $display("FAIL hz_wb_cycle: we=%b hazard=%b fwd1=%b, required 1 %b %b", rf_we, hazard, fwd_rs1_valid, !FWD, FWD);
        end
        vectors++;
        if (fwd_data !== (FWD ? 32'h1234_5678 : 32'd0)) begin
            miscompares++;
            $display("FAIL hz_fwd_data: fwd_data=%h, required %h", fwd_data, FWD ? 32'h1234_5678 : 32'd0);
        end
        tick();
        #1;
        vectors++;
        if (hazard !== 1'b0) begin
            miscompares++;
            $display("FAIL hz_cleared: hazard=%b, required 0", hazard);
        end
        idle();
        tick();
    endtask

    task automatic test_x0();
        do_reset();
        a_valid = 1; a_rd = 0; a_data = 32'hFFFF_FFFF; iss_valid = 1; iss_rd = 0;
        #1;
        vectors++;
        if (a_ready !== 1'b1 || iss_waw !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_issue: a_ready=%b iss_waw=%b, required 1 0", a_ready, iss_waw);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_write: rf_we=%b, required 0", rf_we);
        end
        tick();
    endtask

    task automatic test_waw();
        do_reset();
        iss_valid = 1; iss_rd = 9;
        tick();
        idle(); a_valid = 1; a_rd = 9; a_data = 32'h0000_0099;
        tick();
        idle(); iss_valid = 1; iss_rd = 9; rs2 = 9;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || iss_waw !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_flag: rf_we=%b iss_waw=%b, required 1 1", rf_we, iss_waw);
        end
        tick();
        idle(); rs2 = 9;
        #1;
        vectors++;
        if (hazard !== 1'b1) begin
            miscompares++;
            $display("FAIL waw_persist: hazard=%b, required 1", hazard);
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int r = 1; r <= 3; r++) begin
            iss_valid = 1; iss_rd = 5'(r);
            tick();
        end
        idle(); a_valid = 1; a_rd = 4; a_data = 32'h4444_4444;
        tick();
        idle(); rst = 1;
        #1;
        vectors++;
        if (rf_we !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre: rf_we=%b, required 1", rf_we);
        end
        tick();
        rst = 0;
        #1;
        vectors++;
        if (rf_we !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_we: rf_we=%b, required 0", rf_we);
        end
        for (int r = 0; r < 32; r++) begin
            rs1 = 5'(r); rs2 = 5'(r);
            #1;
            vectors++;
            if (hazard !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_pending: rs=%0d hazard=%b, required 0", r, hazard);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            a_valid = $urandom_range(0, 1); a_rd = 5'($urandom_range(0, 7)); a_data = $urandom;
            b_valid = $urandom_range(0, 1); b_rd = 5'($urandom_range(0, 7)); b_data = $urandom;
            iss_valid = $urandom_range(0, 1); iss_rd = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
            #1;
            vectors++;
            if (a_ready !== e_a_ready() || b_ready !== e_b_ready()) begin
                miscompares++;
                $display("FAIL rnd_grant[%0d]: a_ready=%b b_ready=%b, required %b %b", n, a_ready, b_ready, e_a_ready(), e_b_ready());
            end
            vectors++;
            if (rf_we !== m_we || (m_we && (rf_rd !== m_rd || rf_wdata !== m_data))) begin
                miscompares++;
                $display("FAIL rnd_write[%0d]: we=%b rd=%0d wdata=%h, required %b %0d %h", n, rf_we, rf_rd, rf_wdata, m_we, m_rd, m_data);
            end
            vectors++;
            if (hazard !== e_hazard() || iss_waw !== e_waw()) begin
                miscompares++;
                $display("FAIL rnd_score[%0d]: hazard=%b iss_waw=%b, required %b %b", n, hazard, iss_waw, e_hazard(), e_waw());
            end
            vectors++;
            if (fwd_rs1_valid !== e_fwd(rs1) || fwd_rs2_valid !== e_fwd(rs2) || fwd_data !== (FWD ? m_data : 32'd0)) begin
                miscompares++;
                $display("FAIL rnd_fwd[%0d]: %b %b %h, required %b %b %h", n, fwd_rs1_valid, fwd_rs2_valid, fwd_data, e_fwd(rs1), e_fwd(rs2), FWD ? m_data : 32'd0);
            end
            tick();
        end
        rst = 0;
        idle();
        tick();
    endtask

    initial begin
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_hazard();
        test_x0();
        test_waw();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
